gptp_tx_sched: RTL and testbench

GPTP_TX_SCHED -- requirements
Module: gptp_tx_sched

---
 rtl/gptp_tx_sched_pkg.sv | 27 ++
 rtl/gptp_tx_sched_prio_sel.sv | 21 ++
 rtl/gptp_tx_sched.sv | 138 +++++++++++++
 tb/tb_gptp_tx_sched.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/gptp_tx_sched_pkg.sv
// rtl/gptp_tx_sched_pkg.sv - shared message indices, messageType codes and FSM state type for the gPTP transmit scheduler
package gptp_tx_sched_pkg;

    localparam int unsigned NUM_MSG = 5;

    // Request/ack bit positions
    localparam logic [2:0] MSG_SYNC     = 3'd0;
    localparam logic [2:0] MSG_FU       = 3'd1;
    localparam logic [2:0] MSG_PREQ     = 3'd2;
    localparam logic [2:0] MSG_PRESP    = 3'd3;
    localparam logic [2:0] MSG_PRESP_FU = 3'd4;

    // IEEE 802.1AS messageType codes carried by each frame template
    localparam logic [3:0] MT_SYNC           = 4'h0;
    localparam logic [3:0] MT_FOLLOW_UP      = 4'h8;
    localparam logic [3:0] MT_PDELAY_REQ     = 4'h2;
    localparam logic [3:0] MT_PDELAY_RESP    = 4'h3;
    localparam logic [3:0] MT_PDELAY_RESP_FU = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_DONE
    } state_e;

endpackage

// File: rtl/gptp_tx_sched_prio_sel.sv
// rtl/gptp_tx_sched_prio_sel.sv - combinational fixed-priority picker (3, 4, 0, 1, 2) over five eligible requests
module gptp_prio_sel
    import gptp_tx_sched_pkg::*;
(
    input  logic [4:0] elig, // masked request vector
    output logic [2:0] idx,  // winning message index
    output logic       vld   // at least one eligible request
);

    always_comb begin
        idx = MSG_SYNC;
        vld = 1'b1;
        if (elig[MSG_PRESP])         idx = MSG_PRESP;
        else if (elig[MSG_PRESP_FU]) idx = MSG_PRESP_FU;
        else if (elig[MSG_SYNC])     idx = MSG_SYNC;
        else if (elig[MSG_FU])       idx = MSG_FU;
        else if (elig[MSG_PREQ])     idx = MSG_PREQ;
        else                         vld = 1'b0;
    end

endmodule

// File: rtl/gptp_tx_sched.sv
// rtl/gptp_tx_sched.sv - gPTP transmit scheduler: arbitrates five message requests and sequences one frame at a time to the MAC
module gptp_tx_sched
    import gptp_tx_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 11
) (
    input  logic         clk,
    input  logic         rst_n,       // asynchronous, active low
    input  logic [4:0]   req,         // level requests, one bit per message
    input  logic [399:0] req_data,    // 80-bit payload per request
    output logic [4:0]   ack,         // completion pulse per message
    output logic [7:0]   send_addr,   // one-hot template select
    output logic [79:0]  send_data,   // payload of the granted message
    output logic         send_valid,  // frame offered to MAC
    input  logic         tx_ready,    // MAC accepts offered frame
    input  logic         tx_done,     // MAC finished transmitting
    output logic         busy,        // not idle
    output logic         timeout_err  // transmit completion timed out
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [2:0]      win_q, win_d;
    logic [7:0]      send_addr_q, send_addr_d;
    logic [79:0]     send_data_q, send_data_d;
    logic [4:0]      ack_q, ack_d;
    logic            timeout_err_q, timeout_err_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            sync_pend_q, sync_pend_d;
    logic            presp_pend_q, presp_pend_d;

    logic [4:0]      elig;
    logic [2:0]      sel_idx;
    logic            sel_vld;
    logic [79:0]     win_slice;

    // Follow-up messages are only eligible once their parent has been sent
    assign elig = req & {presp_pend_q, 1'b1, 1'b1, sync_pend_q, 1'b1};

    gptp_prio_sel u_prio_sel (
        .elig (elig),
        .idx  (sel_idx),
        .vld  (sel_vld)
    );

    always_comb begin
        win_slice = '0;
        for (int i = 0; i < NUM_MSG; i++) begin
            if (win_q == i[2:0]) win_slice = req_data[i*80 +: 80];
        end
    end

    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        send_addr_d   = send_addr_q;
        send_data_d   = send_data_q;
        ack_d         = '0;
        timeout_err_d = 1'b0;
        cnt_d         = cnt_q;
        sync_pend_d   = sync_pend_q;
        presp_pend_d  = presp_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    win_d   = sel_idx;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                send_addr_d = 8'b1 << win_q;
                send_data_d = win_slice;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
                // tx_done is checked first so a completion on the last
                // timeout cycle still counts as success
                if (tx_done) begin
                    state_d     = ST_IDLE;
                    send_addr_d = '0;
                    cnt_d       = '0;
                    ack_d       = 5'b1 << win_q;
                    if (win_q == MSG_SYNC)     sync_pend_d  = 1'b1;
                    if (win_q == MSG_FU)       sync_pend_d  = 1'b0;
                    if (win_q == MSG_PRESP)    presp_pend_d = 1'b1;
                    if (win_q == MSG_PRESP_FU) presp_pend_d = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d       = ST_IDLE;
                    send_addr_d   = '0;
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            win_q         <= '0;
            send_addr_q   <= '0;
            send_data_q   <= '0;
            ack_q         <= '0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
            sync_pend_q   <= 1'b0;
            presp_pend_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            send_addr_q   <= send_addr_d;
            send_data_q   <= send_data_d;
            ack_q         <= ack_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
            sync_pend_q   <= sync_pend_d;
            presp_pend_q  <= presp_pend_d;
        end
    end

    assign ack         = ack_q;
    assign send_addr   = send_addr_q;
    assign send_data   = send_data_q;
    assign send_valid  = (state_q == ST_SEND);
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_gptp_tx_sched.sv
// tb/tb_gptp_tx_sched.sv - self-checking bench for gptp_tx_sched with a message-level reference model
module tb_gptp_tx_sched;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [4:0]   req = '0;
    logic [399:0] req_data = '0;
    logic [4:0]   ack;
    logic [7:0]   send_addr;
    logic [79:0]  send_data;
    logic         send_valid;
    logic         tx_ready = 1'b0;
    logic         tx_done = 1'b0;
    logic         busy;
    logic         timeout_err;

    int vecs = 0;
    int errs = 0;

    // reference model state
    bit m_sync  = 1'b0;
    bit m_presp = 1'b0;
    int order[5] = '{3, 4, 0, 1, 2};

    gptp_tx_sched #(.TIMEOUT_CYCLES(TO), .TO_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .send_addr   (send_addr),
        .send_data   (send_data),
        .send_valid  (send_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [399:0] rand400();
        logic [415:0] t;
        for (int i = 0; i < 13; i++) t[i*32 +: 32] = $urandom;
        return t[399:0];
    endfunction

    // Winner under the gating and priority rules; -1 when nothing is eligible
    function automatic int pick(input logic [4:0] r);
        for (int k = 0; k < 5; k++) begin
            int m;
            m = order[k];
            if (r[m] && !(m == 1 && !m_sync) && !(m == 4 && !m_presp)) return m;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"},  send_addr, 0);
        chk({tag, "_data"},  send_data, 0);
        chk({tag, "_valid"}, send_valid, 0);
        chk({tag, "_ack"},   ack, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_terr"},  timeout_err, 0);
    endtask

    // One request episode. done_dly = WAIT_DONE cycle (0-based) carrying tx_done;
    // values >= TO never complete. rst_at >= 0 resets in that WAIT_DONE cycle.
    task automatic txn(input logic [4:0] r, input int rdy_dly, input int done_dly,
                       input bit hold, input int rst_at);
        logic [399:0] d;
        logic [79:0]  exp_data;
        logic [7:0]   exp_addr;
        logic [4:0]   exp_ack;
        int           w;
        bit           to;
        d = rand400();
        req = r;
        req_data = d;
        w = pick(r);
        if (w < 0) begin
            repeat (2) begin
                @(posedge clk); @(negedge clk);
                chk("nogrant_busy", busy, 0);
            end
            req = '0;
            return;
        end
        exp_addr = 8'b1 << w;
        exp_data = d[w*80 +: 80];
        exp_ack  = 5'b1 << w;
        @(posedge clk); @(negedge clk);
        chk("load_busy", busy, 1);
        chk("load_valid", send_valid, 0);
        if (!hold) req = '0;
        @(posedge clk); @(negedge clk);
        req_data = rand400();
        for (int i = 0; i < rdy_dly; i++) begin
            chk("send_valid", send_valid, 1);
            chk("send_addr", send_addr, exp_addr);
            tx_done = 1'($urandom_range(0, 1));
            @(posedge clk); @(negedge clk);
            tx_done = 1'b0;
        end
        chk("send_valid", send_valid, 1);
        chk("send_addr", send_addr, exp_addr);
        chk("send_data", send_data, exp_data);
        tx_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        tx_ready = 1'b0;
        chk("wait_valid", send_valid, 0);
        chk("wait_busy", busy, 1);
        for (int c = 0; c < TO; c++) begin
            chk("wait_addr", send_addr, exp_addr);
            chk("wait_data", send_data, exp_data);
            if (c == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
                m_sync = 1'b0;
                m_presp = 1'b0;
                req = '0;
                return;
            end
            if (c == done_dly) tx_done = 1'b1;
            @(posedge clk); @(negedge clk);
            tx_done = 1'b0;
            if (c == done_dly) break;
        end
        to = (done_dly >= TO);
        chk("end_busy", busy, 0);
        chk("end_addr", send_addr, 0);
        chk("end_ack", ack, to ? 5'b0 : exp_ack);
        chk("end_terr", timeout_err, to);
        if (!to) begin
            if (w == 0) m_sync = 1'b1;
            if (w == 1) m_sync = 1'b0;
            if (w == 3) m_presp = 1'b1;
            if (w == 4) m_presp = 1'b0;
        end
        if (!hold) begin
            @(posedge clk); @(negedge clk);
            chk("post_ack", ack, 0);
            chk("post_terr", timeout_err, 0);
            chk("post_busy", busy, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        txn(5'b00010, 0, 2, 0, -1);    // Follow_Up blocked before Sync
        txn(5'b00001, 0, 2, 0, -1);    // Sync, done 3rd wait cycle
        txn(5'b00010, 1, 0, 0, -1);    // Follow_Up now granted
        txn(5'b00010, 0, 0, 0, -1);    // blocked again
        txn(5'b01101, 0, 1, 1, -1);    // priority order with held requests
        txn(5'b00101, 2, 1, 1, -1);
        txn(5'b00100, 0, 1, 0, -1);
        txn(5'b00100, 0, 100, 0, -1);  // timeout
        txn(5'b00100, 0, 3, 0, -1);    // re-granted
        txn(5'b01000, 0, TO - 1, 0, -1); // done on final timeout cycle
        txn(5'b10000, 0, 4, 0, -1);    // Pdelay_Resp_Follow_Up
        txn(5'b00001, 0, 1, 0, -1);
        txn(5'b01000, 1, 100, 0, 2);   // reset mid WAIT_DONE
        @(negedge clk);
        check_all_zero("after_rst");
        txn(5'b10010, 0, 0, 0, -1);    // flags cleared by reset

        for (int n = 0; n < 40; n++) begin
            txn(5'($urandom), $urandom_range(0, 3), $urandom_range(0, 9), 0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
